// File: rtl/inst_loader_if.sv
// Program-load bus between the serial byte source and the instruction loader.
// Groups the byte handshake, the reload request and every loader output that
// drives the instruction memory.
//   master : byte source / controller side (drives rx_data, rx_valid, start)
//   slave  : loader side (drives rx_ready, inst_in, we, stall, reset_pc,
//            mode, load_done, error)
interface inst_loader_if #(
  parameter int INST_WIDTH = 32
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  start;
  logic [INST_WIDTH-1:0] inst_in;
  logic                  we;
  logic                  stall;
  logic                  reset_pc;
  logic                  mode;
  logic                  load_done;
  logic                  error;

  modport master (
    output rx_data, rx_valid, start,
    input  rx_ready, inst_in, we, stall, reset_pc, mode, load_done, error
  );

  modport slave (
    input  rx_data, rx_valid, start,
    output rx_ready, inst_in, we, stall, reset_pc, mode, load_done, error
  );
endinterface

// File: rtl/inst_loader.sv
// Instruction loader: receives a program over a byte stream and writes it into
// the instruction memory, then releases the core.
// Stream format: 4-byte big-endian word count N, followed by N big-endian
// 32-bit instruction words.
// Ports:
//   clk   : single clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : inst_loader_if.slave
//             rx_data/rx_valid/rx_ready : byte handshake (transfer on valid&&ready)
//             start     : reload request, honoured only while executing
//             inst_in   : assembled word to instruction memory
//             we        : instruction memory write enable
//             stall     : instruction memory PC hold
//             reset_pc  : force instruction memory PC to 0
//             mode      : 0 = load, 1 = execute
//             load_done : program loaded, core running
//             error     : header word count exceeds memory depth
module inst_loader #(
  parameter int INST_WIDTH     = 32,
  parameter int INST_MEM_WIDTH = 15
) (
  input logic          clk,
  input logic          reset,
  inst_loader_if.slave bus
);

  typedef enum logic [2:0] {
    CLR,
    HDR,
    BYTES,
    WRITE,
    FIN,
    EXEC,
    ERR
  } state_t;

  localparam logic [31:0]             DEPTH    = 32'd1 << INST_MEM_WIDTH;
  localparam logic [INST_MEM_WIDTH:0] ONE_WORD = (INST_MEM_WIDTH + 1)'(1);

  state_t                  state_q, state_d;
  logic [1:0]              byte_cnt_q, byte_cnt_d;
  logic [23:0]             shift_q, shift_d;
  logic [INST_MEM_WIDTH:0] remaining_q, remaining_d;
  logic [INST_WIDTH-1:0]   inst_q, inst_d;
  logic [31:0]             word;
  logic                    xfer;

  logic reset_pc_q, reset_pc_d;
  logic stall_q, stall_d;
  logic we_q, we_d;
  logic rx_ready_q, rx_ready_d;
  logic mode_q, mode_d;
  logic load_done_q, load_done_d;
  logic error_q, error_d;

  assign xfer = bus.rx_valid && rx_ready_q;
  // Three buffered bytes plus the byte on the bus form the complete word on
  // the cycle the fourth byte is transferred.
  assign word = {shift_q, bus.rx_data};

  // Next state, datapath and output decode
  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    shift_d     = shift_q;
    remaining_d = remaining_q;
    inst_d      = inst_q;

    case (state_q)
      CLR: begin
        byte_cnt_d = '0;
        state_d    = HDR;
      end
      HDR: begin
        if (xfer) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          shift_d    = {shift_q[15:0], bus.rx_data};
          if (byte_cnt_q == 2'd3) begin
            if (word == 32'd0) begin
              state_d = FIN;
            end else if (word > DEPTH) begin
              state_d = ERR;
            end else begin
              remaining_d = word[INST_MEM_WIDTH:0];
              state_d     = BYTES;
            end
          end
        end
      end
      BYTES: begin
        if (xfer) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          shift_d    = {shift_q[15:0], bus.rx_data};
          if (byte_cnt_q == 2'd3) begin
            inst_d  = word;
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        remaining_d = remaining_q - ONE_WORD;
        state_d     = (remaining_q == ONE_WORD) ? FIN : BYTES;
      end
      FIN: begin
        state_d = EXEC;
      end
      EXEC: begin
        if (bus.start) begin
          state_d = CLR;
        end
      end
      ERR: begin
        state_d = ERR;
      end
      default: begin
        state_d = ERR;
      end
    endcase

    // Outputs are a decode of the state being entered, so they are registered
    // together with it and line up cycle-for-cycle with the state.
    reset_pc_d  = (state_d == CLR) || (state_d == FIN);
    stall_d     = !((state_d == WRITE) || (state_d == EXEC));
    we_d        = (state_d == WRITE);
    rx_ready_d  = (state_d == HDR) || (state_d == BYTES);
    mode_d      = (state_d == EXEC);
    load_done_d = (state_d == EXEC);
    error_d     = (state_d == ERR);
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= CLR;
      byte_cnt_q  <= '0;
      remaining_q <= '0;
      inst_q      <= '0;
      reset_pc_q  <= 1'b1;
      stall_q     <= 1'b1;
      we_q        <= 1'b0;
      rx_ready_q  <= 1'b0;
      mode_q      <= 1'b0;
      load_done_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      remaining_q <= remaining_d;
      inst_q      <= inst_d;
      reset_pc_q  <= reset_pc_d;
      stall_q     <= stall_d;
      we_q        <= we_d;
      rx_ready_q  <= rx_ready_d;
      mode_q      <= mode_d;
      load_done_q <= load_done_d;
      error_q     <= error_d;
    end
  end

  // Byte buffer: every byte is shifted in again after the counter restarts,
  // so stale contents never reach a completed word.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign bus.inst_in   = inst_q;
  assign bus.we        = we_q;
  assign bus.stall     = stall_q;
  assign bus.reset_pc  = reset_pc_q;
  assign bus.rx_ready  = rx_ready_q;
  assign bus.mode      = mode_q;
  assign bus.load_done = load_done_q;
  assign bus.error     = error_q;

endmodule
